// File: rtl/area_perim_pkg.sv
// Shared types and width helpers for the area/perimeter op unit and its multiplier.
package area_perim_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int AREA_W(input int w);
        return 2 * w;
    endfunction

    function automatic int PERIM_W(input int w);
        return w + 2;
    endfunction

    // Wide enough to hold the value W itself, not just W-1.
    function automatic int CNT_W(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/area_perim_seq_mul.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, W cycles per product.
module ap_seq_mul
    import area_perim_pkg::*;
#(
    parameter int W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [W-1:0]          mcand,
    input  logic [W-1:0]          mplier,
    output logic                  done,
    output logic [AREA_W(W)-1:0]  product
);

    localparam int PW = AREA_W(W);
    localparam int CW = CNT_W(W);
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    logic          busy_q;
    logic [CW-1:0] cnt_q;
    logic [PW-1:0] mcand_q;
    logic [W-1:0]  mplier_q;
    logic [PW-1:0] prod_q;
    logic [PW-1:0] prod_d;

    // product is the result of the current step, so it is final while done is high.
    always_comb begin
        prod_d  = prod_q + (mplier_q[0] ? mcand_q : '0);
        done    = busy_q && (cnt_q == LAST);
        product = prod_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q   <= 1'b0;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
        end else if (start) begin
            busy_q   <= 1'b1;
            cnt_q    <= '0;
            mcand_q  <= PW'(mcand);
            mplier_q <= mplier;
            prod_q   <= '0;
        end else if (busy_q) begin
            prod_q   <= prod_d;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + 1'b1;
            if (done) begin
                busy_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/area_perim_seq.sv
// Rectangle area/perimeter op unit with valid/ready handshakes on both sides.
// Define AREA_PERIM_ACCUM_EN to add a running area accumulator on the acc port.
module area_perim_seq
    import area_perim_pkg::*;
#(
    parameter int W     = 8,
    parameter int ACC_W = 24
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [W-1:0]           a,
    input  logic [W-1:0]           b,
    input  logic [W-1:0]           c,
    input  logic [W-1:0]           d,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [AREA_W(W)-1:0]   area,
    output logic [PERIM_W(W)-1:0]  perim,
    output logic                   degen,
    input  logic                   acc_clr,
    output logic [ACC_W-1:0]       acc
);

    localparam int AW  = AREA_W(W);
    localparam int PMW = PERIM_W(W);

    state_t         state_q, state_d;
    logic [W-1:0]   dx, dy;
    logic [PMW-1:0] perimNext;
    logic           accept, finish, mulDone;
    logic [AW-1:0]  mulProduct;
    logic [AW-1:0]  area_q;
    logic [PMW-1:0] perim_q;
    logic           degen_q;

    assign dx        = (c >= a) ? c - a : a - c;
    assign dy        = (d >= b) ? d - b : b - d;
    assign perimNext = (PMW'(dx) << 1) + (PMW'(dy) << 1);
    assign accept    = in_valid && (state_q == IDLE);
    assign finish    = (state_q == MUL) && mulDone;

    ap_seq_mul #(.W(W)) uMul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (accept),
        .mcand   (dx),
        .mplier  (dy),
        .done    (mulDone),
        .product (mulProduct)
    );

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = MUL;
            end
            MUL: begin
                if (mulDone) state_d = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Perimeter and degeneracy are known at accept; area lands on the last multiply step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            area_q  <= '0;
            perim_q <= '0;
            degen_q <= 1'b0;
        end else begin
            if (accept) begin
                perim_q <= perimNext;
                degen_q <= (dx == '0) || (dy == '0);
            end
            if (finish) begin
                area_q <= mulProduct;
            end
        end
    end

    assign area  = area_q;
    assign perim = perim_q;
    assign degen = degen_q;

`ifdef AREA_PERIM_ACCUM_EN
    logic [ACC_W-1:0] acc_q, acc_d;

    // Clear takes effect before the add, so a coincident clear leaves just the new area.
    always_comb begin
        acc_d = acc_clr ? '0 : acc_q;
        if (finish) begin
            acc_d = acc_d + ACC_W'(mulProduct);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc = acc_q;
`else
    logic unusedAccClr;
    assign unusedAccClr = acc_clr;
    assign acc          = '0;
`endif

endmodule
